window_cache: RTL

- Buffering stage directly downstream of the memory controller.
- Accepts one packed dual-window entry per cycle: 2 help-request flags plus two 80-bit column windows (10 columns x 8 bit each).
- Stores entries in an in-order FIFO and delivers them to the PE-side consumer on read request, with a registered output.
- Flags empty/full, counts occupancy and help-mode entries, and flags overflow attempts so the controller can stall.

---
 rtl/window_cache.sv | 108 ++++++++++
 1 files changed

// File: rtl/window_cache.sv
// In-order FIFO of packed dual-window entries between the memory controller and the PE array.
// Registered pop output, registered empty/full/count, saturating help counters and sticky overflow.
module window_cache #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 10,
  parameter int CACHE_WIDTH = 2 * DATA_WIDTH * BLOCK_WIDTH,
  parameter int DEPTH       = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     wr_en,
  input  logic [CACHE_WIDTH+1:0]   data_in,
  input  logic                     read_req,
  output logic [CACHE_WIDTH-1:0]   column_out,
  output logic [1:0]               help_out,
  output logic                     out_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_WIDTH-1:0]     help_cnt_a,
  output logic [CNT_WIDTH-1:0]     help_cnt_b,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CACHE_WIDTH+1:0] mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            wr_ptr_nxt;
  logic [AW:0]            rd_ptr_nxt;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   wr_rej;
  logic [CACHE_WIDTH+1:0] rd_entry;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
    if (inc && (cnt != {CNT_WIDTH{1'b1}}))
      return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return cnt;
  endfunction

  // Accept decisions use the registered flags, so a full FIFO rejects a write even when a read pops in the same cycle
  always_comb begin
    wr_acc     = clk_en & wr_en & ~full;
    rd_acc     = clk_en & read_req & ~empty;
    wr_rej     = clk_en & wr_en & full;
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_acc};
    rd_entry   = mem[rd_ptr[AW-1:0]];
  end

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // Pointers, flags and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      count  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Registered pop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      column_out <= '0;
      help_out   <= '0;
      out_valid  <= 1'b0;
    end else if (clk_en) begin
      out_valid <= rd_acc;
      if (rd_acc) begin
        column_out <= rd_entry[CACHE_WIDTH-1:0];
        help_out   <= rd_entry[CACHE_WIDTH+1:CACHE_WIDTH];
      end
    end
  end

  // Help-entry statistics and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      help_cnt_a <= '0;
      help_cnt_b <= '0;
      overflow   <= 1'b0;
    end else begin
      help_cnt_a <= sat_inc(help_cnt_a, wr_acc & data_in[CACHE_WIDTH+1]);
      help_cnt_b <= sat_inc(help_cnt_b, wr_acc & data_in[CACHE_WIDTH]);
      overflow   <= overflow | wr_rej;
    end
  end

endmodule
